// File: rtl/seg14_scroll_mux.sv
// Time-multiplexed 14-segment bank driver: scans NUM_DIGITS selects from a
// host-writable message buffer, with optional wrap-around scrolling.
module seg14_scroll_mux #(
  parameter int NUM_DIGITS    = 12,
  parameter int MSG_DEPTH     = 32,
  parameter int REFRESH_DIV   = 1,
  parameter int SCROLL_FRAMES = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [13:0]                  wr_data,
  input  logic [$clog2(MSG_DEPTH):0]   msg_len,
  input  logic                         scroll_en,
  input  logic                         blank,
  output logic [NUM_DIGITS-1:0]        sel,
  output logic [13:0]                  segm,
  output logic                         frame_tick
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  localparam logic [AW:0]   DEPTH_L = MSG_DEPTH[AW:0];
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] D_MAX   = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FC_MAX  = FW'(SCROLL_FRAMES - 1);

  logic [13:0]           mem [MSG_DEPTH];
  logic [PW-1:0]         pre;
  logic [DW-1:0]         d;
  logic [AW-1:0]         rp;
  logic [AW-1:0]         offset;
  logic [FW-1:0]         fc;

  logic [AW:0]           len;
  logic                  slot_end;
  logic                  frame_end;
  logic                  wr_ok;
  logic [AW:0]           rp_p1;
  logic [AW-1:0]         rp_step;
  logic [AW:0]           off_p1;
  logic [AW-1:0]         offset_nxt;
  logic [FW-1:0]         fc_nxt;
  logic [13:0]           pattern;
  logic [NUM_DIGITS-1:0] onehot;

  assign len       = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
  assign slot_end  = (pre == PRE_MAX);
  assign frame_end = slot_end && (d == D_MAX);
  assign onehot    = NUM_DIGITS'(1) << d;

  // Compare with >= so a pointer stranded past a shrunken length still wraps.
  assign rp_p1   = {1'b0, rp} + (AW+1)'(1);
  assign rp_step = (rp_p1 >= len) ? '0 : rp_p1[AW-1:0];
  assign off_p1  = {1'b0, offset} + (AW+1)'(1);

  generate
    if ((1 << AW) == MSG_DEPTH) begin : g_full_addr
      assign wr_ok = 1'b1;
    end else begin : g_part_addr
      assign wr_ok = (32'(wr_addr) < MSG_DEPTH);
    end
  endgenerate

  // Scroll position for the next frame; only committed on frame_end.
  always_comb begin
    offset_nxt = offset;
    fc_nxt     = fc;
    if (!scroll_en || (len == '0)) begin
      offset_nxt = '0;
      fc_nxt     = '0;
    end else begin
      fc_nxt = (fc == FC_MAX) ? '0 : fc + FW'(1);
      if ({1'b0, offset} >= len) begin
        offset_nxt = '0;
      end else if (fc == FC_MAX) begin
        offset_nxt = (off_p1 >= len) ? '0 : off_p1[AW-1:0];
      end
    end
  end

  always_comb begin
    pattern = '0;
    if (len != '0) begin
      if (scroll_en) begin
        pattern = mem[rp];
      end else if (32'(d) < 32'(len)) begin
        pattern = mem[rp];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      d          <= '0;
      rp         <= '0;
      offset     <= '0;
      fc         <= '0;
      sel        <= '0;
      segm       <= '0;
      frame_tick <= 1'b0;
    end else begin
      pre        <= slot_end ? '0 : pre + PW'(1);
      frame_tick <= frame_end;
      sel        <= blank ? '0 : onehot;
      segm       <= blank ? '0 : pattern;
      if (frame_end) begin
        d      <= '0;
        rp     <= offset_nxt;
        offset <= offset_nxt;
        fc     <= fc_nxt;
      end else if (slot_end) begin
        d  <= d + DW'(1);
        rp <= rp_step;
      end
    end
  end

endmodule

// File: doc/seg14_scroll_mux.md
Name: seg14_scroll_mux

Overview:
- Parametrised time-multiplexed driver for a common-select 14-segment display bank.
- Holds a writable message buffer of 14-bit segment patterns. Scans NUM_DIGITS digits one at a time. Optionally scrolls the message across the bank with wrap-around.
- Replaces fixed-text display drivers. The text comes from a host-writable buffer, so no hard-coded character constants are needed.
- Sits between the user-area logic and the display pads (sel, segm).

Parameters:
- NUM_DIGITS, 12, number of digit selects; >= 2.
- MSG_DEPTH, 32, message buffer entries (14 bits each); >= 2.
- REFRESH_DIV, 1, clocks per digit slot; >= 1.
- SCROLL_FRAMES, 64, complete frames per scroll step; >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe for the message buffer.
- wr_addr  input  clog2(MSG_DEPTH)  write address.
- wr_data  input  14  segment pattern to write (bit 13 = segment a, as in existing glyph tables).
- msg_len  input  clog2(MSG_DEPTH)+1  number of valid buffer entries; values above MSG_DEPTH saturate to MSG_DEPTH.
- scroll_en  input  1  1 = scrolling mode, 0 = static mode.
- blank  input  1  forces the display dark.
- sel  output  NUM_DIGITS  one-hot digit select, registered.
- segm  output  14  segment pattern for the selected digit, registered.
- frame_tick  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (async assert, sync release): sel=0, segm=0, frame_tick=0. Prescaler, digit counter, read pointer, offset and frame counter all 0. Every buffer entry = 0.
- Writes: when wr_en is high, mem[wr_addr] <= wr_data on that edge. Writes are accepted at any time, including during blank.
- Read-before-write: if the entry written is read in the same cycle, the output shows the old value. The new value appears on the next visit to that entry.
- Prescaler: pre counts 0..REFRESH_DIV-1. slot_end = (pre == REFRESH_DIV-1).
- Digit counter d: advances on slot_end and wraps NUM_DIGITS-1 -> 0. Wrap point = frame end.
- frame_tick: registered pulse in the cycle after the frame-end edge.
- Read pointer rp: loaded with offset when d wraps to 0. Otherwise, on each slot_end, rp <= (rp+1 == L) ? 0 : rp+1, where L = saturated msg_len. No modulo hardware.
- Selected pattern:
  - L == 0: pattern = 0.
  - Static mode: pattern = mem[rp] if d < L, else 0. Digits beyond the message are blank.
  - Scroll mode: pattern = mem[rp] for every digit. The message repeats if L < NUM_DIGITS.
- Output register: every cycle, sel <= blank ? 0 : (1 << d) and segm <= blank ? 0 : pattern. Output latency is exactly 1 clock from the d/rp state. Counters keep running while blank is high.
- Scroll: frame counter fc increments at each frame end. When fc == SCROLL_FRAMES-1, fc <= 0 and offset <= (offset+1 == L) ? 0 : offset+1.
- Offset rules, applied at frame end only:
  - Scroll mode with L == 0: offset frozen at 0.
  - scroll_en low: offset <= 0 and fc <= 0.
  - offset >= L (msg_len reduced): offset <= 0.
- Offset changes are sampled only at frame boundaries, so a frame is never torn.
- Mode changes mid-frame: scroll_en and msg_len changes take effect for pattern selection immediately, but rp continues from its current value until the next frame start.
- Reset mid-frame: all outputs go to 0 asynchronously. After release, scanning restarts at digit 0 with offset 0, and buffer contents are lost.
- sel is never multi-hot in any cycle. While blank is low, sel is exactly one-hot.

Test Plan:
- Basic scan (NUM_DIGITS=4, REFRESH_DIV=1, msg_len=3, scroll off; write mem[0..2]=0x3BC0/0x1F00/0x33C0): starting 1 clock after reset release, (sel,segm) cycles (0001,0x3BC0),(0010,0x1F00),(0100,0x33C0),(1000,0x0000); frame_tick pulses once every 4 clocks.
- Prescale (REFRESH_DIV=3): each sel value is held exactly 3 clocks; frame_tick period = 12 clocks.
- Scroll wrap (NUM_DIGITS=4, msg_len=3, SCROLL_FRAMES=1, scroll on):
  - frame k shows entries (k mod 3), ((k+1) mod 3), ... across digits 0..3;
  - digit 3 repeats the digit-0 entry when offset=0;
  - after 3 frames, offset returns to 0.
- Boundaries:
  - msg_len=0 -> segm=0 for all digits while sel still scans;
  - msg_len=40 with MSG_DEPTH=32 -> behaves as 32;
  - shrinking msg_len below offset -> offset=0 at the next frame start.
- Blank and write collision:
  - blank=1 -> sel=0, segm=0 one clock later, and the digit sequence resumes in phase when released;
  - a write to the entry shown in the same cycle -> old value is shown, new value on the next frame.
- Async reset asserted mid-frame in scroll mode: sel/segm go to 0 without a clock edge; after release, digit 0 shows 0x0000 until rewritten.
